gan_result_reader: RTL

- Readout end of the GAN inference path: consumes the 9 generator pixel outputs and the discriminator score of the GAN top level.
- Tracks which cycles carried a real sample into the GAN pipeline (issue tag), captures the matching results after the fixed pipeline latency, and buffers them as frames.
- Streams each frame out as 10 words over a valid/ready interface toward the host/readout logic.

---
 rtl/gan_result_reader.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/gan_result_reader.sv
// -----------------------------------------------------------------------------
// gan_result_reader
//   Readout end of the GAN inference path. Each issue pulse launches a
//   {valid, choice} tag down a LATENCY-deep pipeline; when the tag reaches the
//   tail, the nine generator pixels plus the discriminator score are captured
//   as one frame into a FRAME_DEPTH-entry frame buffer. Buffered frames are
//   streamed out as 10 words (pixels 1x1..3x3, then score) on a valid/ready
//   interface. A capture that finds the buffer full (with no simultaneous pop)
//   is dropped, setting the sticky overflow flag and bumping drop_cnt.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   issue, issue_choice      sample-entry pulse and its choice tag
//   pixel_1x1..pixel_3x3     generator outputs (WIDTH, signed, passed as-is)
//   score                    discriminator output (WIDTH, signed)
//   out_data/out_idx         streamed word and its index 0..9
//   out_last                 high on idx 9
//   out_choice               choice tag of the frame being streamed
//   out_valid/out_ready      stream handshake
//   overflow, drop_cnt       sticky drop flag, saturating drop count
//   busy                     tags in flight, frames buffered or streaming
// -----------------------------------------------------------------------------
module gan_result_reader #(
   parameter int WIDTH       = 32,
   parameter int LATENCY     = 5,
   parameter int FRAME_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             issue,
   input  logic             issue_choice,
   input  logic [WIDTH-1:0] pixel_1x1,
   input  logic [WIDTH-1:0] pixel_1x2,
   input  logic [WIDTH-1:0] pixel_1x3,
   input  logic [WIDTH-1:0] pixel_2x1,
   input  logic [WIDTH-1:0] pixel_2x2,
   input  logic [WIDTH-1:0] pixel_2x3,
   input  logic [WIDTH-1:0] pixel_3x1,
   input  logic [WIDTH-1:0] pixel_3x2,
   input  logic [WIDTH-1:0] pixel_3x3,
   input  logic [WIDTH-1:0] score,
   output logic [WIDTH-1:0] out_data,
   output logic [3:0]       out_idx,
   output logic             out_last,
   output logic             out_choice,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overflow,
   output logic [7:0]       drop_cnt,
   output logic             busy
);

   localparam int          PW       = $clog2(FRAME_DEPTH);
   localparam int          NWORDS   = 10;
   localparam logic [3:0]  LAST_IDX = 4'd9;

   localparam logic [0:0]  ST_IDLE  = 1'b0;
   localparam logic [0:0]  ST_SEND  = 1'b1;

   // tag pipeline
   logic [LATENCY-1:0] r_tag_v;
   logic [LATENCY-1:0] r_tag_c;

   // frame buffer
   logic [WIDTH-1:0]   r_mem   [0:FRAME_DEPTH-1][0:NWORDS-1];
   logic               r_mem_c [0:FRAME_DEPTH-1];
   logic [PW:0]        r_wr_ptr;
   logic [PW:0]        r_rd_ptr;

   // stream FSM and status
   logic [0:0]         r_state;
   logic [3:0]         r_idx;
   logic               r_ovf;
   logic [7:0]         r_drop;

   logic [WIDTH-1:0]   w_frame [0:NWORDS-1];
   logic               w_capture;
   logic               w_empty;
   logic               w_full;
   logic               w_xfer;
   logic               w_pop;
   logic               w_wr_en;
   logic               w_drop;
   logic [PW-1:0]      w_wr_slot;
   logic [PW-1:0]      w_rd_slot;
   logic [PW:0]        w_wr_nxt;
   logic [PW:0]        w_rd_nxt;

   // ---------------------------------------------------------------------------
   // Tag pipeline: stage 0 loads {issue, issue_choice}; the tail stage is
   // valid exactly LATENCY cycles after the issue cycle.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tag_v <= '0;
         r_tag_c <= '0;
      end else begin
         r_tag_v[0] <= issue;
         r_tag_c[0] <= issue_choice;
         for (int unsigned i = 1; i < LATENCY; i++) begin
            r_tag_v[i] <= r_tag_v[i-1];
            r_tag_c[i] <= r_tag_c[i-1];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Capture / pop decisions
   // ---------------------------------------------------------------------------
   always_comb begin
      w_frame[0] = pixel_1x1;
      w_frame[1] = pixel_1x2;
      w_frame[2] = pixel_1x3;
      w_frame[3] = pixel_2x1;
      w_frame[4] = pixel_2x2;
      w_frame[5] = pixel_2x3;
      w_frame[6] = pixel_3x1;
      w_frame[7] = pixel_3x2;
      w_frame[8] = pixel_3x3;
      w_frame[9] = score;
   end

   assign w_capture = r_tag_v[LATENCY-1];
   assign w_wr_slot = r_wr_ptr[PW-1:0];
   assign w_rd_slot = r_rd_ptr[PW-1:0];
   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   // extra pointer bit distinguishes full from empty when the slots coincide
   assign w_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (w_wr_slot == w_rd_slot);

   assign w_xfer    = (r_state == ST_SEND) && out_ready;
   assign w_pop     = w_xfer && (r_idx == LAST_IDX);
   // a pop completing this cycle frees the very slot the capture writes into
   assign w_wr_en   = w_capture && (!w_full || w_pop);
   assign w_drop    = w_capture && w_full && !w_pop;

   assign w_wr_nxt  = r_wr_ptr + {{PW{1'b0}}, w_wr_en};
   assign w_rd_nxt  = r_rd_ptr + {{PW{1'b0}}, w_pop};

   // ---------------------------------------------------------------------------
   // Frame storage (data only, no reset needed: contents are only observed
   // through the pointers, which are reset)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         for (int unsigned i = 0; i < NWORDS; i++) begin
            r_mem[w_wr_slot][i] <= w_frame[i];
         end
         r_mem_c[w_wr_slot] <= r_tag_c[LATENCY-1];
      end
   end

   // ---------------------------------------------------------------------------
   // Pointers, stream FSM, word index, drop accounting
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_state  <= ST_IDLE;
         r_idx    <= '0;
         r_ovf    <= 1'b0;
         r_drop   <= '0;
      end else begin
         r_wr_ptr <= w_wr_nxt;
         r_rd_ptr <= w_rd_nxt;

         case (r_state)
            ST_IDLE: begin
               if (w_wr_en) begin
                  r_state <= ST_SEND;
               end
            end
            ST_SEND: begin
               // leave SEND only when the pop empties the buffer and no
               // capture refills it in the same cycle
               if (w_pop && (w_wr_nxt == w_rd_nxt)) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         if (w_xfer) begin
            r_idx <= (r_idx == LAST_IDX) ? 4'd0 : r_idx + 4'd1;
         end

         if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_drop != 8'hFF) begin
               r_drop <= r_drop + 8'd1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs: head frame word selected by the read slot and word index; held
   // stable under backpressure since neither changes without a transfer and
   // the head slot is never written while occupied.
   // ---------------------------------------------------------------------------
   assign out_valid  = (r_state == ST_SEND);
   assign out_data   = out_valid ? r_mem[w_rd_slot][r_idx] : '0;
   assign out_idx    = r_idx;
   assign out_last   = out_valid && (r_idx == LAST_IDX);
   assign out_choice = out_valid ? r_mem_c[w_rd_slot] : 1'b0;
   assign overflow   = r_ovf;
   assign drop_cnt   = r_drop;
   assign busy       = (|r_tag_v) || !w_empty || out_valid;

endmodule
